// File: rtl/oled_frame_sequencer.sv
// Power-up, init and full-frame streaming sequencer for a 128x32 SSD1306 behind a byte-wide I2C writer.
// Optional build macro: OLED_SEQ_AUTOREFRESH_EN adds a periodic self-refresh timer.
module oled_frame_sequencer #(
    parameter int POWERUP_DLY = 25000,
    parameter int COLS        = 128,
    parameter int PAGES       = 4
`ifdef OLED_SEQ_AUTOREFRESH_EN
    ,
    parameter int REFRESH_PERIOD = 1250000
`endif
) (
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic       iRefresh,
    output logic [8:0] oRdAddr,
    input  logic [7:0] iRdData,
    output logic       oCall,
    output logic [7:0] oCtrl,
    output logic [7:0] oData,
    input  logic       iDone,
    output logic       oReady,
    output logic       oFrameDone
);

    localparam int         PWR_W    = $clog2(POWERUP_DLY + 1);
    localparam logic [8:0] LAST_IDX = 9'(COLS * PAGES - 1);

    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_IDLE, S_WIN, S_FETCH, S_SEND, S_FIN
    } state_t;

    state_t           state_q;
    logic [PWR_W-1:0] pwr_cnt_q;
    logic [4:0]       cmd_idx_q;
    logic [8:0]       byte_idx_q;
    logic [8:0]       rd_addr_q;
    logic             phase_q;
    logic             pend_q;
    logic             call_q;
    logic [7:0]       ctrl_q;
    logic [7:0]       data_q;
    logic             ready_q;
    logic             frame_done_q;

`ifdef OLED_SEQ_AUTOREFRESH_EN
    localparam int    RCNT_W = $clog2(REFRESH_PERIOD + 1);
    logic [RCNT_W-1:0] rcnt_q;
`endif

    function automatic logic [7:0] init_byte(input logic [4:0] i);
        case (i)
            5'd0:  return 8'hAE;
            5'd1:  return 8'hD5;
            5'd2:  return 8'h80;
            5'd3:  return 8'hA8;
            5'd4:  return 8'h1F;
            5'd5:  return 8'hD3;
            5'd6:  return 8'h00;
            5'd7:  return 8'h40;
            5'd8:  return 8'h8D;
            5'd9:  return 8'h14;
            5'd10: return 8'h20;
            5'd11: return 8'h00;
            5'd12: return 8'hA1;
            5'd13: return 8'hC8;
            5'd14: return 8'hDA;
            5'd15: return 8'h02;
            5'd16: return 8'h81;
            5'd17: return 8'h8F;
            5'd18: return 8'hD9;
            5'd19: return 8'hF1;
            5'd20: return 8'hDB;
            5'd21: return 8'h40;
            5'd22: return 8'hA4;
            5'd23: return 8'hA6;
            default: return 8'hAF;
        endcase
    endfunction

    // Column range 0..COLS-1, page range 0..PAGES-1.
    function automatic logic [7:0] win_byte(input logic [2:0] i);
        case (i)
            3'd0: return 8'h21;
            3'd1: return 8'h00;
            3'd2: return 8'(COLS - 1);
            3'd3: return 8'h22;
            3'd4: return 8'h00;
            default: return 8'(PAGES - 1);
        endcase
    endfunction

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= S_PWR;
            pwr_cnt_q    <= '0;
            cmd_idx_q    <= '0;
            byte_idx_q   <= '0;
            rd_addr_q    <= '0;
            phase_q      <= 1'b0;
            pend_q       <= 1'b0;
            call_q       <= 1'b0;
            ctrl_q       <= 8'h00;
            data_q       <= 8'h00;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef OLED_SEQ_AUTOREFRESH_EN
            rcnt_q       <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            if (iRefresh && state_q != S_IDLE)
                pend_q <= 1'b1;
`ifdef OLED_SEQ_AUTOREFRESH_EN
            if (state_q != S_PWR && state_q != S_INIT) begin
                if (rcnt_q == RCNT_W'(REFRESH_PERIOD - 1)) begin
                    rcnt_q <= '0;
                    pend_q <= 1'b1;
                end else begin
                    rcnt_q <= rcnt_q + 1'b1;
                end
            end
`endif
            case (state_q)
                S_PWR: begin
                    if (pwr_cnt_q == PWR_W'(POWERUP_DLY - 1)) begin
                        state_q   <= S_INIT;
                        cmd_idx_q <= '0;
                        ctrl_q    <= 8'h00;
                        data_q    <= init_byte(5'd0);
                        call_q    <= 1'b1;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + 1'b1;
                    end
                end
                // A low oCall cycle separates consecutive calls; iDone only counts while calling.
                S_INIT: begin
                    if (!call_q) begin
                        data_q <= init_byte(cmd_idx_q);
                        call_q <= 1'b1;
                    end else if (iDone) begin
                        call_q <= 1'b0;
                        if (cmd_idx_q == 5'd24) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
`ifdef OLED_SEQ_AUTOREFRESH_EN
                            rcnt_q  <= '0;
`endif
                        end else begin
                            cmd_idx_q <= cmd_idx_q + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (pend_q || iRefresh) begin
                        pend_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        cmd_idx_q <= '0;
                        state_q   <= S_WIN;
                    end
                end
                S_WIN: begin
                    if (!call_q) begin
                        ctrl_q <= 8'h00;
                        data_q <= win_byte(cmd_idx_q[2:0]);
                        call_q <= 1'b1;
                    end else if (iDone) begin
                        call_q <= 1'b0;
                        if (cmd_idx_q == 5'd5) begin
                            state_q    <= S_FETCH;
                            byte_idx_q <= '0;
                            rd_addr_q  <= '0;
                            phase_q    <= 1'b0;
                        end else begin
                            cmd_idx_q <= cmd_idx_q + 1'b1;
                        end
                    end
                end
                // Address was presented on entry; the RAM answers one cycle later.
                S_FETCH: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        data_q  <= iRdData;
                        ctrl_q  <= 8'h40;
                        call_q  <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (iDone) begin
                        call_q <= 1'b0;
                        if (byte_idx_q == LAST_IDX) begin
                            state_q <= S_FIN;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            rd_addr_q  <= byte_idx_q + 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    frame_done_q <= 1'b1;
                    ready_q      <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_PWR;
            endcase
        end
    end

    assign oRdAddr    = rd_addr_q;
    assign oCall      = call_q;
    assign oCtrl      = ctrl_q;
    assign oData      = data_q;
    assign oReady     = ready_q;
    assign oFrameDone = frame_done_q;

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Directed bench for oled_frame_sequencer: writer model answers each call after ~10 cycles,
// a scoreboard queue holds the expected {ctrl,data} of every call in order.
module tb_oled_frame_sequencer;

    logic       CLOCK;
    logic       RST_n;
    logic       iRefresh;
    logic [8:0] oRdAddr;
    logic [7:0] iRdData;
    logic       oCall;
    logic [7:0] oCtrl;
    logic [7:0] oData;
    logic       iDone;
    logic       oReady;
    logic       oFrameDone;

    logic       wr_done;
    logic       spur_done;
    logic [7:0] ram [0:511];
    logic [7:0] rd_data;

    logic [15:0] exp_q[$];
    int n_vec;
    int n_err;
    int call_cnt;
    int data_cnt;
    int fd_cnt;

    assign iDone   = wr_done | spur_done;
    assign iRdData = rd_data;

    oled_frame_sequencer #(.POWERUP_DLY(100)) dut (
        .CLOCK      (CLOCK),
        .RST_n      (RST_n),
        .iRefresh   (iRefresh),
        .oRdAddr    (oRdAddr),
        .iRdData    (iRdData),
        .oCall      (oCall),
        .oCtrl      (oCtrl),
        .oData      (oData),
        .iDone      (iDone),
        .oReady     (oReady),
        .oFrameDone (oFrameDone)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        for (int a = 0; a < 512; a++) ram[a] = 8'(a);
    end

    always @(posedge CLOCK) rd_data <= ram[oRdAddr];

    // Writer model: one iDone pulse roughly 10 cycles after each oCall rise.
    initial begin
        int cnt;
        logic wprev;
        cnt = 0;
        wprev = 1'b0;
        wr_done = 1'b0;
        forever begin
            @(negedge CLOCK);
            wr_done = 1'b0;
            if (!RST_n) begin
                cnt = 0;
                wprev = 1'b0;
            end else begin
                if (oCall && !wprev) begin
                    cnt = 9;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) wr_done = 1'b1;
                end
                wprev = oCall;
            end
        end
    end

    // Call monitor: scoreboard pop on every rise, stability check while oCall stays high.
    initial begin
        logic        mprev;
        logic [15:0] held;
        logic [15:0] exp_v;
        mprev = 1'b0;
        held = '0;
        call_cnt = 0;
        data_cnt = 0;
        fd_cnt = 0;
        forever begin
            @(negedge CLOCK);
            if (!RST_n) begin
                mprev = 1'b0;
            end else begin
                if (oFrameDone) fd_cnt++;
                if (oCall && !mprev) begin
                    call_cnt++;
                    if (oCtrl == 8'h40) data_cnt++;
                    held = {oCtrl, oData};
                    n_vec++;
                    assert (exp_q.size() != 0) else begin
                        n_err++;
                        $error("FAIL call_unexpected: got ctrl=%h data=%h, required no call", oCtrl, oData);
                    end
                    if (exp_q.size() != 0) begin
                        exp_v = exp_q.pop_front();
                        n_vec++;
                        assert ({oCtrl, oData} === exp_v) else begin
                            n_err++;
                            $error("FAIL call_byte #%0d: got ctrl/data=%h, required %h", call_cnt, {oCtrl, oData}, exp_v);
                        end
                    end
                end else if (oCall) begin
                    n_vec++;
                    assert ({oCtrl, oData} === held) else begin
                        n_err++;
                        $error("FAIL call_stable: got ctrl/data=%h, required %h", {oCtrl, oData}, held);
                    end
                end
                mprev = oCall;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    task automatic push_init();
        logic [7:0] rom [0:24];
        rom = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F,
                8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        for (int i = 0; i < 25; i++) exp_q.push_back({8'h00, rom[i]});
    endtask

    task automatic push_frame();
        logic [7:0] win [0:5];
        win = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};
        for (int i = 0; i < 6; i++) exp_q.push_back({8'h00, win[i]});
        for (int i = 0; i < 512; i++) exp_q.push_back({8'h40, 8'(i)});
    endtask

    task automatic pulse_refresh();
        @(negedge CLOCK);
        iRefresh = 1'b1;
        @(negedge CLOCK);
        iRefresh = 1'b0;
    endtask

    task automatic wait_ready(input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge CLOCK);
            if (oReady) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_frame_done(input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge CLOCK);
            if (oFrameDone) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int first;
        int fd_base;
        int call_base;
        int data_base;
        n_vec = 0;
        n_err = 0;
        RST_n = 1'b0;
        iRefresh = 1'b0;
        spur_done = 1'b0;

        // Reset state
        repeat (3) @(negedge CLOCK);
        chk("rst_call", oCall, 0);
        chk("rst_ctrl", oCtrl, 8'h00);
        chk("rst_data", oData, 8'h00);
        chk("rst_addr", oRdAddr, 0);
        chk("rst_ready", oReady, 0);
        chk("rst_frame_done", oFrameDone, 0);

        // Power-up delay and init sequence
        push_init();
        call_base = call_cnt;
        RST_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLOCK);
            if (oCall) begin
                first = k;
                break;
            end
        end
        chk("pwr_first_call_cycle", first, 100);
        chk("first_call_data", oData, 8'hAE);
        chk("first_call_ctrl", oCtrl, 8'h00);
        chk("ready_low_in_init", oReady, 0);
        wait_ready(1000, ok);
        chk("init_ready_timeout", ok, 1);
        chk("init_call_count", call_cnt - call_base, 25);
        chk("init_call_low_at_ready", oCall, 0);
        chk("init_queue_empty", exp_q.size(), 0);

        // Spurious iDone while idle must be ignored
        @(negedge CLOCK);
        spur_done = 1'b1;
        @(negedge CLOCK);
        spur_done = 1'b0;
        repeat (40) @(negedge CLOCK);
        chk("spur_idle_call", oCall, 0);
        chk("spur_idle_ready", oReady, 1);

        // Full frame from an explicit refresh, with a spurious iDone in a window gap
        push_frame();
        fd_base = fd_cnt;
        pulse_refresh();
        @(negedge CLOCK);
        chk("frame_ready_low", oReady, 0);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLOCK);
            if (oCall) begin
                ok = 1'b1;
                break;
            end
        end
        chk("win_first_call_timeout", ok, 1);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLOCK);
            if (!oCall) begin
                ok = 1'b1;
                break;
            end
        end
        chk("win_first_fall_timeout", ok, 1);
        spur_done = 1'b1;
        @(negedge CLOCK);
        spur_done = 1'b0;
        wait_frame_done(12000, ok);
        chk("frame_done_timeout", ok, 1);
        chk("frame_done_ready", oReady, 1);
        chk("frame_done_call_low", oCall, 0);
        @(negedge CLOCK);
        chk("frame_done_one_cycle", oFrameDone, 0);
        chk("frame_done_count", fd_cnt - fd_base, 1);
        chk("frame_queue_empty", exp_q.size(), 0);
        chk("frame_last_addr", oRdAddr, 9'd511);

        // Three refresh requests during init merge into one frame
        @(negedge CLOCK);
        RST_n = 1'b0;
        repeat (2) @(negedge CLOCK);
        exp_q.delete();
        push_init();
        push_frame();
        fd_base = fd_cnt;
        RST_n = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLOCK);
            if (oCall) begin
                ok = 1'b1;
                break;
            end
        end
        chk("init2_first_call_timeout", ok, 1);
        for (int p = 0; p < 3; p++) begin
            pulse_refresh();
            repeat (30) @(negedge CLOCK);
        end
        chk("init2_ready_low", oReady, 0);
        wait_frame_done(12000, ok);
        chk("merged_frame_timeout", ok, 1);
        repeat (300) @(negedge CLOCK);
        chk("merged_frame_count", fd_cnt - fd_base, 1);
        chk("merged_queue_empty", exp_q.size(), 0);
        chk("merged_idle_call", oCall, 0);
        chk("merged_idle_ready", oReady, 1);

        // Reset in the middle of data byte 300
        push_frame();
        data_base = data_cnt;
        fd_base = fd_cnt;
        pulse_refresh();
        ok = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge CLOCK);
            if ((data_cnt - data_base) == 301 && oCall) begin
                ok = 1'b1;
                break;
            end
        end
        chk("byte300_timeout", ok, 1);
        chk("byte300_data", oData, 8'(300));
        #2;
        RST_n = 1'b0;
        #1;
        chk("midreset_call_drop", oCall, 0);
        chk("midreset_ready", oReady, 0);
        chk("midreset_addr", oRdAddr, 0);
        @(negedge CLOCK);
        exp_q.delete();
        @(negedge CLOCK);
        push_init();
        RST_n = 1'b1;
        wait_ready(1000, ok);
        chk("restart_ready_timeout", ok, 1);
        chk("restart_queue_empty", exp_q.size(), 0);
        repeat (20) @(negedge CLOCK);
        chk("restart_no_frame_done", fd_cnt - fd_base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
